// File: rtl/dcache_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// dcache_pkg : shared types, constants and width helpers for the D-cache data path
// Rev 1.0
// ------------------------------------------------------------------
package dcache_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned BYTE_OFF_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WB_RD  = 2'd2,
    ST_WB_OUT = 2'd3
  } dcache_state_e;

  // Index/select fields never shrink below one bit, even for a single way, set or word.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of the set-index field inside a request address.
  function automatic int unsigned idx_lsb(input int unsigned line_words);
    return BYTE_OFF_W + $clog2(line_words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_data_array_if.sv
`default_nettype none
// ------------------------------------------------------------------
// dcache_data_array_if : CPU-hit, refill and writeback signals of the D-cache data array
// Rev 1.0
// ------------------------------------------------------------------
interface dcache_data_array_if #(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 2,
  parameter int unsigned ADDR_W     = 64
);
  import dcache_pkg::*;

  localparam int unsigned WAY_W = clog2_min1(WAYS);
  localparam int unsigned IDX_W = clog2_min1(SETS);

  logic                req_valid;
  logic                req_we;
  logic [STRB_W-1:0]   req_wstrb;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_cacheable;
  logic [WAYS-1:0]     hit_way;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                busy;

  logic                refill_start;
  logic [WAY_W-1:0]    refill_way;
  logic [IDX_W-1:0]    refill_index;
  logic                refill_beat_valid;
  logic [DATA_W-1:0]   refill_beat_data;
  logic                refill_done;

  logic                wb_start;
  logic [WAY_W-1:0]    wb_way;
  logic [IDX_W-1:0]    wb_index;
  logic                wb_beat_valid;
  logic [DATA_W-1:0]   wb_beat_data;
  logic                wb_beat_ready;
  logic                wb_done;

  // Tag/control unit plus AXI bridge side.
  modport master (
    output req_valid, req_we, req_wstrb, req_addr, req_wdata, req_cacheable, hit_way,
    output refill_start, refill_way, refill_index, refill_beat_valid, refill_beat_data,
    output wb_start, wb_way, wb_index, wb_beat_ready,
    input  rsp_valid, rsp_rdata, busy, refill_done, wb_beat_valid, wb_beat_data, wb_done
  );

  // Data array side.
  modport slave (
    input  req_valid, req_we, req_wstrb, req_addr, req_wdata, req_cacheable, hit_way,
    input  refill_start, refill_way, refill_index, refill_beat_valid, refill_beat_data,
    input  wb_start, wb_way, wb_index, wb_beat_ready,
    output rsp_valid, rsp_rdata, busy, refill_done, wb_beat_valid, wb_beat_data, wb_done
  );

endinterface
`default_nettype wire

// File: rtl/dcache_way_bank.sv
`default_nettype none
// ------------------------------------------------------------------
// dcache_way_bank : one way of data storage, byte-strobe write, registered 1-cycle read
// Rev 1.0
// ------------------------------------------------------------------
module dcache_way_bank
  import dcache_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset; read data holds until the next read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dcache_data_array.sv
`default_nettype none
// ------------------------------------------------------------------
// dcache_data_array : N-way D-cache data store with hit access, line refill and writeback FSM
// Rev 1.0
// ------------------------------------------------------------------
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 2,
  parameter int unsigned ADDR_W     = 64
) (
  input  logic               clk,
  input  logic               rst,
  dcache_data_array_if.slave dc_if
);

  localparam int unsigned WAY_W   = clog2_min1(WAYS);
  localparam int unsigned IDX_W   = clog2_min1(SETS);
  localparam int unsigned WORD_W  = clog2_min1(LINE_WORDS);
  localparam int unsigned WOFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned IOFF_W  = $clog2(SETS);
  localparam int unsigned IDX_LSB = idx_lsb(LINE_WORDS);
  localparam int unsigned BANK_AW = clog2_min1(SETS * LINE_WORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  dcache_state_e      state_q, state_d;
  logic [WORD_W-1:0]  cnt_q, cnt_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               refill_done_q, refill_done_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_load_q, rsp_load_d;
  logic [WAY_W-1:0]   rsp_way_q, rsp_way_d;

  logic [WORD_W-1:0]  w_req_word;
  logic [IDX_W-1:0]   w_req_idx;
  logic [WAY_W-1:0]   w_hit_way;
  logic               w_hit_any;
  logic               w_wb_done;
  logic [WAYS-1:0]    w_we;
  logic [WAYS-1:0]    w_re;
  logic [IDX_W-1:0]   w_addr_idx;
  logic [WORD_W-1:0]  w_addr_word;
  logic [BANK_AW-1:0] w_bank_addr;
  logic [STRB_W-1:0]  w_wstrb;
  logic [DATA_W-1:0]  w_wdata;
  logic [DATA_W-1:0]  w_bank_rdata [WAYS];
  logic               w_unused_addr;

  if (LINE_WORDS > 1) begin : g_word_field
    assign w_req_word = dc_if.req_addr[BYTE_OFF_W +: WORD_W];
  end else begin : g_word_none
    assign w_req_word = '0;
  end

  if (SETS > 1) begin : g_idx_field
    assign w_req_idx = dc_if.req_addr[IDX_LSB +: IDX_W];
  end else begin : g_idx_none
    assign w_req_idx = '0;
  end

  // Tag bits and byte offset play no part in the data array.
  assign w_unused_addr = ^{dc_if.req_addr[ADDR_W-1:IDX_LSB+IOFF_W],
                           dc_if.req_addr[BYTE_OFF_W-1:0]};

  // Descending scan so the lowest set bit of a non-one-hot vector is the one kept.
  always_comb begin
    w_hit_way = '0;
    w_hit_any = 1'b0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (dc_if.hit_way[w]) begin
        w_hit_way = WAY_W'(w);
        w_hit_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    way_d         = way_q;
    idx_d         = idx_q;
    refill_done_d = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_load_d    = 1'b0;
    rsp_way_d     = rsp_way_q;
    w_wb_done     = 1'b0;
    w_we          = '0;
    w_re          = '0;
    w_addr_idx    = idx_q;
    w_addr_word   = cnt_q;
    w_wstrb       = '1;
    w_wdata       = dc_if.refill_beat_data;

    case (state_q)
      ST_IDLE: begin
        if (dc_if.wb_start) begin
          way_d   = dc_if.wb_way;
          idx_d   = dc_if.wb_index;
          cnt_d   = '0;
          state_d = ST_WB_RD;
        end else if (dc_if.refill_start) begin
          way_d   = dc_if.refill_way;
          idx_d   = dc_if.refill_index;
          cnt_d   = '0;
          state_d = ST_REFILL;
        end else if (dc_if.req_valid && dc_if.req_cacheable && w_hit_any) begin
          w_addr_idx  = w_req_idx;
          w_addr_word = w_req_word;
          w_wstrb     = dc_if.req_wstrb;
          w_wdata     = dc_if.req_wdata;
          if (dc_if.req_we) begin
            w_we[w_hit_way] = 1'b1;
          end else begin
            w_re[w_hit_way] = 1'b1;
          end
          rsp_valid_d = 1'b1;
          rsp_load_d  = ~dc_if.req_we;
          rsp_way_d   = w_hit_way;
        end
      end

      ST_REFILL: begin
        if (dc_if.refill_beat_valid) begin
          w_we[way_q] = 1'b1;
          if (cnt_q == LAST_WORD) begin
            cnt_d         = '0;
            refill_done_d = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            cnt_d = cnt_q + WORD_W'(1);
          end
        end
      end

      ST_WB_RD: begin
        w_re[way_q] = 1'b1;
        state_d     = ST_WB_OUT;
      end

      ST_WB_OUT: begin
        if (dc_if.wb_beat_ready) begin
          if (cnt_q == LAST_WORD) begin
            w_wb_done = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + WORD_W'(1);
            state_d = ST_WB_RD;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      way_q         <= '0;
      idx_q         <= '0;
      refill_done_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_load_q    <= 1'b0;
      rsp_way_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      way_q         <= way_d;
      idx_q         <= idx_d;
      refill_done_q <= refill_done_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_load_q    <= rsp_load_d;
      rsp_way_q     <= rsp_way_d;
    end
  end

  // Line-major layout: all words of one set sit next to each other in a bank.
  assign w_bank_addr = (BANK_AW'(w_addr_idx) << WOFF_W) | BANK_AW'(w_addr_word);

  for (genvar w = 0; w < int'(WAYS); w++) begin : g_way
    dcache_way_bank #(
      .DEPTH (SETS * LINE_WORDS),
      .AW    (BANK_AW)
    ) u_bank (
      .clk     (clk),
      .we_i    (w_we[w] & ~rst),
      .re_i    (w_re[w] & ~rst),
      .addr_i  (w_bank_addr),
      .wstrb_i (w_wstrb),
      .wdata_i (w_wdata),
      .rdata_o (w_bank_rdata[w])
    );
  end

  // Bank read data is only meaningful in the cycle it was asked for, so gate it.
  assign dc_if.rsp_valid     = rsp_valid_q;
  assign dc_if.rsp_rdata     = (rsp_valid_q && rsp_load_q) ? w_bank_rdata[rsp_way_q] : '0;
  assign dc_if.busy          = (state_q != ST_IDLE);
  assign dc_if.refill_done   = refill_done_q;
  assign dc_if.wb_beat_valid = (state_q == ST_WB_OUT);
  assign dc_if.wb_beat_data  = (state_q == ST_WB_OUT) ? w_bank_rdata[way_q] : '0;
  assign dc_if.wb_done       = w_wb_done;

endmodule
`default_nettype wire
